// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite master adapter: turns a valid/ready command stream into pipelined single transfers
// and returns one registered response pulse per command, in order.
module mfp_ahb_lite_master #(
   parameter logic [3:0]  HPROT_VAL   = 4'b0011,
   parameter logic [31:0] RESET_HADDR = 32'h0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [2:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] HADDR,
   output logic [2:0]  HBURST,
   output logic        HMASTLOCK,
   output logic [3:0]  HPROT,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HSIZE_32      = 3'b010;

   logic        a_valid;
   logic [31:0] a_addr;
   logic        a_write;
   logic [2:0]  a_size;
   logic [31:0] a_wdata;

   logic        d_valid;
   logic        d_write;
   logic [31:0] d_wdata;

   logic        cmd_accept;

   // A-stage may only change when empty or when the bus advances, so address/control
   // stay frozen through wait states.
   assign cmd_ready  = !a_valid || HREADY;
   assign cmd_accept = cmd_valid && cmd_ready;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         a_valid   <= 1'b0;
         a_addr    <= RESET_HADDR;
         a_write   <= 1'b0;
         a_size    <= HSIZE_32;
         a_wdata   <= 32'h0;
         d_valid   <= 1'b0;
         d_write   <= 1'b0;
         d_wdata   <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         if (HREADY) begin
            d_valid <= a_valid;
            d_write <= a_write;
            d_wdata <= a_wdata;
         end

         if (cmd_accept) begin
            a_valid <= 1'b1;
            a_addr  <= cmd_addr;
            a_write <= cmd_write;
            a_size  <= cmd_size;
            a_wdata <= cmd_wdata;
         end else if (HREADY) begin
            a_valid <= 1'b0;
         end

         rsp_valid <= d_valid && HREADY;
         rsp_rdata <= (d_valid && !d_write && HREADY) ? HRDATA : 32'h0;
         rsp_err   <= HRESP;
      end
   end

   assign HTRANS    = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR     = a_valid ? a_addr  : RESET_HADDR;
   assign HWRITE    = a_valid ? a_write : 1'b0;
   assign HSIZE     = a_valid ? a_size  : HSIZE_32;
   assign HWDATA    = (d_valid && d_write) ? d_wdata : 32'h0;
   assign HBURST    = HBURST_SINGLE;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = HPROT_VAL;

endmodule
